// File: rtl/dsp48e_uint_cmult_unpack.sv
// rtl/dsp48e_uint_cmult_unpack.sv - unpack DSP48E packed conj(a)*b words and accumulate per window
module dsp48e_uint_cmult_unpack #(
  parameter int BITWIDTH      = 4,
  parameter int DSP_B_WIDTH   = 18,
  parameter int PADDING_WIDTH = DSP_B_WIDTH - 1 - 2*BITWIDTH,
  parameter int FIELD         = BITWIDTH + PADDING_WIDTH,
  parameter int ACC_LEN       = 16,
  parameter int OUT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [47:0]          p_in,
  input  logic                 p_valid,
  input  logic                 sync,
  output logic [OUT_WIDTH-1:0] out_real,
  output logic [OUT_WIDTH-1:0] out_imag,
  output logic                 out_valid,
  output logic                 out_overflow
);

  localparam int HI_W  = 48 - 2*FIELD;
  localparam int IW    = OUT_WIDTH + 1;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  // stage 1: raw fields
  logic [FIELD-1:0] lo_q, lo_d, mid_q, mid_d;
  logic [HI_W-1:0]  hi_q, hi_d;
  logic             v1_q, v1_d, s1_q, s1_d;

  // stage 2: real/imag contributions of one word
  logic [OUT_WIDTH-1:0] real_s_q, real_s_d;
  logic [IW-1:0]        imag_s_q, imag_s_d;
  logic                 v2_q, v2_d, s2_q, s2_d;

  // accumulation and outputs
  logic [OUT_WIDTH-1:0] acc_real_q, acc_real_d, acc_imag_q, acc_imag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic                 out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;

  logic [OUT_WIDTH:0]   sum_real;
  logic [OUT_WIDTH-1:0] imag_add, sum_imag;
  logic                 imag_ovf, load_ovf, ovf_new;
  logic [CNT_W-1:0]     cnt_eff;
  logic                 ovf_eff;

  always_comb begin
    lo_d  = p_in[FIELD-1:0];
    mid_d = p_in[2*FIELD-1:FIELD];
    hi_d  = p_in[47:2*FIELD];
    v1_d  = p_valid;
    s1_d  = sync;

    real_s_d = OUT_WIDTH'(mid_q);
    imag_s_d = IW'(hi_q) - IW'(lo_q);
    v2_d     = v1_q;
    s2_d     = s1_q;
  end

  always_comb begin
    acc_real_d  = acc_real_q;
    acc_imag_d  = acc_imag_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;

    imag_add = imag_s_q[OUT_WIDTH-1:0];
    sum_real = {1'b0, acc_real_q} + {1'b0, real_s_q};
    sum_imag = acc_imag_q + imag_add;
    imag_ovf = (acc_imag_q[OUT_WIDTH-1] == imag_add[OUT_WIDTH-1]) &&
               (sum_imag[OUT_WIDTH-1] != acc_imag_q[OUT_WIDTH-1]);
    // a difference that does not fit the output width is already an overflow
    load_ovf = imag_s_q[OUT_WIDTH] ^ imag_s_q[OUT_WIDTH-1];

    // sync restarts the window before this word is considered
    cnt_eff = s2_q ? '0 : cnt_q;
    ovf_eff = s2_q ? 1'b0 : ovf_q;
    ovf_new = ovf_eff;
    if (s2_q) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    if (v2_q) begin
      if (cnt_eff == '0) begin
        acc_real_d = real_s_q;
        acc_imag_d = imag_add;
        ovf_new    = load_ovf;
      end else begin
        acc_real_d = sum_real[OUT_WIDTH-1:0];
        acc_imag_d = sum_imag;
        ovf_new    = ovf_eff | sum_real[OUT_WIDTH] | imag_ovf | load_ovf;
      end

      if (cnt_eff == CNT_LAST) begin
        out_real_d  = acc_real_d;
        out_imag_d  = acc_imag_d;
        out_ovf_d   = ovf_new;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        cnt_d = cnt_eff + CNT_W'(1);
        ovf_d = ovf_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q        <= '0;
      mid_q       <= '0;
      hi_q        <= '0;
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      real_s_q    <= '0;
      imag_s_q    <= '0;
      v2_q        <= 1'b0;
      s2_q        <= 1'b0;
      acc_real_q  <= '0;
      acc_imag_q  <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      lo_q        <= lo_d;
      mid_q       <= mid_d;
      hi_q        <= hi_d;
      v1_q        <= v1_d;
      s1_q        <= s1_d;
      real_s_q    <= real_s_d;
      imag_s_q    <= imag_s_d;
      v2_q        <= v2_d;
      s2_q        <= s2_d;
      acc_real_q  <= acc_real_d;
      acc_imag_q  <= acc_imag_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_real     = out_real_q;
  assign out_imag     = out_imag_q;
  assign out_valid    = out_valid_q;
  assign out_overflow = out_ovf_q;

endmodule
